// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//   Drives a multiplexed hex display one digit at a time. A debug word is
//   captured into a shadow register and copied to the display register only
//   at a frame boundary, so one scan frame never mixes two values.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   value_in     word to display (4*NUM_DIGITS bits)
//   value_load   capture value_in this cycle
//   display_en   0 = all digits dark; scanning, loads and frame_done continue
//   digit_data   nibble for the currently enabled digit (to the 7-seg decoder)
//   digit_sel_n  active-low digit enables, at most one bit low
//   frame_done   one-cycle pulse after the scan wraps from the last digit to 0
module hex_display_scanner #(
  parameter int NUM_DIGITS          = 8,
  parameter int REFRESH_DIV         = 50000,
  parameter int BLANK_LEADING_ZEROS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    value_load,
  input  logic                    display_en,
  output logic [3:0]              digit_data,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic                    frame_done
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      div_cnt_q,     div_cnt_d;
  logic [IDX_W-1:0]      digit_idx_q,   digit_idx_d;
  logic [VAL_W-1:0]      shadow_q,      shadow_d;
  logic [VAL_W-1:0]      disp_q,        disp_d;
  logic                  pending_q,     pending_d;
  logic [3:0]            digit_data_q,  digit_data_d;
  logic [NUM_DIGITS-1:0] digit_sel_n_q, digit_sel_n_d;
  logic                  frame_done_q,  frame_done_d;

  logic                  step;
  logic                  boundary;
  logic [VAL_W-1:0]      upper_nibbles;
  logic                  zero_blank;
  logic                  digit_lit;

  always_comb begin
    step     = (div_cnt_q == DIV_LAST);
    boundary = step && (digit_idx_q == IDX_LAST);

    // Divider and digit scan
    div_cnt_d   = step ? '0 : div_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (step) begin
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
    end

    // Shadow / display transfer. A load on the boundary cycle goes straight
    // to the display so the newest value wins and nothing stays pending.
    shadow_d  = value_load ? value_in : shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    if (boundary) begin
      if (value_load) begin
        disp_d = value_in;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (value_load) begin
      pending_d = 1'b1;
    end

    // Nibbles digit_idx..NUM_DIGITS-1; the low nibble is the current digit.
    upper_nibbles = disp_q >> {digit_idx_q, 2'b00};

    // Digit 0 is never zero-blanked so a zero value still shows one "0".
    zero_blank = (BLANK_LEADING_ZEROS != 0) && (digit_idx_q != '0) &&
                 (upper_nibbles == '0);
    digit_lit  = display_en && !zero_blank;

    // Output registers are computed from the current index, so they trail
    // the internal scan state by one cycle.
    digit_data_d  = upper_nibbles[3:0];
    digit_sel_n_d = digit_lit ? ~(NUM_DIGITS'(1) << digit_idx_q) : '1;
    frame_done_d  = boundary;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      digit_idx_q   <= '0;
      shadow_q      <= '0;
      disp_q        <= '0;
      pending_q     <= 1'b0;
      digit_data_q  <= '0;
      digit_sel_n_q <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      digit_idx_q   <= digit_idx_d;
      shadow_q      <= shadow_d;
      disp_q        <= disp_d;
      pending_q     <= pending_d;
      digit_data_q  <= digit_data_d;
      digit_sel_n_q <= digit_sel_n_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign digit_data  = digit_data_q;
  assign digit_sel_n = digit_sel_n_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
module tb_hex_display_scanner;

  localparam int N = 8;
  localparam int R = 4;
  localparam int FRAME = N * R;

  logic        clk;
  logic        reset;
  logic [31:0] value_in;
  logic        value_load;
  logic        display_en;

  logic [3:0]  digit_data;
  logic [7:0]  digit_sel_n;
  logic        frame_done;
  logic [3:0]  digit_data_nb;
  logic [7:0]  digit_sel_n_nb;
  logic        frame_done_nb;

  int total;
  int bad;

  // Reference model state: cycles since reset, displayed and pending words.
  bit          m_valid;
  int          m_cyc;
  logic [31:0] m_disp;
  logic [31:0] m_shadow;
  bit          m_pend;
  logic [7:0]  e_sel;
  logic [7:0]  e_sel_nb;
  logic [3:0]  e_data;
  logic        e_fd;

  hex_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_LEADING_ZEROS(1)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .value_load  (value_load),
    .display_en  (display_en),
    .digit_data  (digit_data),
    .digit_sel_n (digit_sel_n),
    .frame_done  (frame_done)
  );

  hex_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_LEADING_ZEROS(0)) u_dut_nb (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .value_load  (value_load),
    .display_en  (display_en),
    .digit_data  (digit_data_nb),
    .digit_sel_n (digit_sel_n_nb),
    .frame_done  (frame_done_nb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What the display must show after this edge, from the digit currently
  // being scanned (cycle count / R) and the word that frame displays.
  task automatic model_step();
    int          d;
    logic [31:0] up;
    bit          bnd;
    if (reset) begin
      m_valid  = 1'b1;
      m_cyc    = 0;
      m_disp   = '0;
      m_shadow = '0;
      m_pend   = 1'b0;
      e_sel    = 8'hFF;
      e_sel_nb = 8'hFF;
      e_data   = 4'h0;
      e_fd     = 1'b0;
    end else if (m_valid) begin
      d        = (m_cyc / R) % N;
      up       = m_disp >> (4 * d);
      e_data   = up[3:0];
      e_sel    = (display_en && !(d > 0 && up == 32'h0)) ? ~(8'h01 << d) : 8'hFF;
      e_sel_nb = display_en ? ~(8'h01 << d) : 8'hFF;
      bnd      = (m_cyc % FRAME) == FRAME - 1;
      e_fd     = bnd;
      if (value_load) m_shadow = value_in;
      if (bnd) begin
        if (value_load)  m_disp = value_in;
        else if (m_pend) m_disp = m_shadow;
        m_pend = 1'b0;
      end else if (value_load) begin
        m_pend = 1'b1;
      end
      m_cyc++;
    end
  endtask

  // One clock: advance the model on the edge, compare both DUTs mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (m_valid) begin
      check("sel",     {24'h0, digit_sel_n},    {24'h0, e_sel});
      check("data",    {28'h0, digit_data},     {28'h0, e_data});
      check("fd",      {31'h0, frame_done},     {31'h0, e_fd});
      check("sel_nb",  {24'h0, digit_sel_n_nb}, {24'h0, e_sel_nb});
      check("data_nb", {28'h0, digit_data_nb},  {28'h0, e_data});
      check("fd_nb",   {31'h0, frame_done_nb},  {31'h0, e_fd});
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Returns at the first sampling point where frame_done is high.
  task automatic sync_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      tick();
      if (frame_done) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL sync_frame: actual=no frame_done required=pulse within %0d cycles", 3 * FRAME);
    end
  endtask

  task automatic load(input logic [31:0] v);
    value_in   = v;
    value_load = 1'b1;
    tick();
    value_load = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    m_valid    = 1'b0;
    reset      = 1'b1;
    value_in   = '0;
    value_load = 1'b0;
    display_en = 1'b1;

    ticks(2);
    check("rst_sel", {24'h0, digit_sel_n}, 32'h0000_00FF);
    check("rst_data", {28'h0, digit_data}, 32'h0);
    check("rst_fd", {31'h0, frame_done}, 32'h0);
    reset = 1'b0;
    tick();
    check("first_sel", {24'h0, digit_sel_n}, 32'h0000_00FE);
    check("first_data", {28'h0, digit_data}, 32'h0);

    // Idle: value 0 shows a single "0" on digit 0; frame_done every 32 cycles.
    ticks(40);
    sync_frame();
    ticks(FRAME);
    check("fd_period", {31'h0, frame_done}, 32'h1);

    // Mid-frame load: current frame keeps the old value.
    ticks(10);
    load(32'h1234_ABCD);
    ticks(2);
    check("old_frame_sel", {24'h0, digit_sel_n}, 32'h0000_00FF);
    sync_frame();
    ticks(2 + 4 * 3);
    check("abcd_d3_data", {28'h0, digit_data}, 32'h0000_000A);
    check("abcd_d3_sel", {24'h0, digit_sel_n}, 32'h0000_00F7);

    // Leading-zero suppression vs. all digits lit.
    load(32'h0000_00F0);
    sync_frame();
    ticks(2 + 4 * 1);
    check("f0_d1_data", {28'h0, digit_data}, 32'h0000_000F);
    check("f0_d1_sel", {24'h0, digit_sel_n}, 32'h0000_00FD);
    ticks(4);
    check("f0_d2_sel", {24'h0, digit_sel_n}, 32'h0000_00FF);
    check("f0_d2_sel_nb", {24'h0, digit_sel_n_nb}, 32'h0000_00FB);
    check("f0_d2_data", {28'h0, digit_data}, 32'h0);

    // Back-to-back loads within one frame: only the last is shown.
    sync_frame();
    ticks(5);
    load(32'h1111_1111);
    ticks(3);
    load(32'h2222_2222);
    sync_frame();
    ticks(2);
    check("last_load_d0", {28'h0, digit_data}, 32'h0000_0002);

    // Load exactly on the frame-boundary step.
    sync_frame();
    ticks(FRAME - 1);
    load(32'h5555_5555);
    check("bnd_fd", {31'h0, frame_done}, 32'h1);
    ticks(2);
    check("bnd_d0_data", {28'h0, digit_data}, 32'h0000_0005);
    sync_frame();
    ticks(2 + 4 * 7);
    check("bnd_next_d7_data", {28'h0, digit_data}, 32'h0000_0005);
    check("bnd_next_d7_sel", {24'h0, digit_sel_n}, 32'h0000_007F);

    // Display disabled for a frame: dark, but frame_done keeps its schedule.
    sync_frame();
    display_en = 1'b0;
    ticks(12);
    check("dis_sel", {24'h0, digit_sel_n}, 32'h0000_00FF);
    ticks(FRAME - 12);
    check("dis_fd", {31'h0, frame_done}, 32'h1);
    check("dis_sel_end", {24'h0, digit_sel_n}, 32'h0000_00FF);
    display_en = 1'b1;

    // Reset at digit 5 with a load pending.
    sync_frame();
    ticks(4);
    load(32'h9999_9999);
    ticks(17);
    reset = 1'b1;
    tick();
    check("midrst_sel", {24'h0, digit_sel_n}, 32'h0000_00FF);
    check("midrst_data", {28'h0, digit_data}, 32'h0);
    reset = 1'b0;
    tick();
    check("postrst_sel", {24'h0, digit_sel_n}, 32'h0000_00FE);
    check("postrst_data", {28'h0, digit_data}, 32'h0);
    ticks(40);
    sync_frame();
    ticks(2);
    check("no_stale_d0", {28'h0, digit_data}, 32'h0);
    ticks(4 * 4);
    check("no_stale_d4_sel", {24'h0, digit_sel_n}, 32'h0000_00FF);
    check("no_stale_d4_data", {28'h0, digit_data}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
